i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit address this responder answers to.
REQ-002 SHALL have port clk, input, 1: system clock; one clock domain, all flops on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port scl, inout wire, 1: I2C clock, read only, never driven (no clock stretching).
REQ-005 SHALL have port sda, inout wire, 1: I2C data, open-drain; driven 1'b0 or released to 1'bz, never driven 1.
REQ-006 SHALL have port rx_data, output, 8: last byte written by master, MSB-first assembled.
REQ-007 SHALL have port rx_valid, output, 1: one-clk pulse when rx_data updates.
REQ-008 SHALL have port rx_ready, input, 1: sink can accept byte; sampled to choose ACK/NACK.
REQ-009 SHALL have port tx_data, input, 8: byte to return on master read.
REQ-010 SHALL have port tx_req, output, 1: one-clk pulse when tx_data is latched; user presents next byte before next latch.
REQ-011 SHALL have port busy, output, 1: high from address match until STOP/abort.

Function
REQ-012 SHALL pass scl and sda through 2-FF synchronizers plus one history flop; edge events are flagged on the clk cycle the synchronized level changes.
REQ-013 SHALL detect START as synchronized SDA fall while SCL high and STOP as SDA rise while SCL high.
REQ-014 SHALL sample SDA on SCL rising events and change its SDA drive only on SCL falling events.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-016 SHALL go to ADDR, bit counter = 7, on START from any state, including repeated START.
REQ-017 SHALL go to IDLE, release SDA and drop busy on STOP from any state.
REQ-018 ADDR: SHALL shift 8 bits (7 address + R/W); after bit 0, match → ADDR_ACK, drive SDA 0 on the next SCL fall, set busy; mismatch → IDLE with SDA released.
REQ-019 ADDR_ACK: on the SCL fall ending the ACK bit, SHALL enter WR_DATA (R/W=0) and release SDA, or enter RD_DATA (R/W=1) and latch tx_data, pulse tx_req and drive bit 7.
REQ-020 WR_DATA: after the 8th rising event SHALL update rx_data, pulse rx_valid the next clk, and enter WR_ACK; ACK (SDA 0) if rx_ready is high on that cycle, else NACK (released).
REQ-021 WR_ACK: on SCL fall SHALL release SDA; after ACK → WR_DATA; after NACK → IDLE (busy low, ignore bus until START).
REQ-022 RD_DATA: SHALL drive 0 for data bit 0 and release for bit 1, MSB first; after 8th bit, release SDA on SCL fall and enter RD_ACK.
REQ-023 RD_ACK: on rising event, sampled 0 (master ACK) SHALL latch the next tx_data and pulse tx_req on the following SCL fall and re-enter RD_DATA; sampled 1 (NACK) → IDLE.
REQ-024 Bit counter SHALL be 4 bits; down-count 7→0 per byte with no wrap beyond a byte.
REQ-025 rx_valid and tx_req SHALL each be high exactly one clk per byte, never simultaneously.
REQ-026 SCL high time SHALL be at least 4 clk periods for correct operation; slower SCL is unrestricted.

Reset
REQ-027 On rst SHALL force state IDLE, SDA released, rx_data 8'h00, rx_valid 0, tx_req 0, busy 0, synchronizer flops 1.
REQ-028 Reset mid-transfer SHALL release SDA in the same cycle the reset takes effect; next action is only on a new START.

Structure
REQ-029 state_t enum and I2C constants (ACK=0, NACK=1) SHALL live in shared package i2c_pkg, also used by i2c_master.
REQ-030 Synchronizer and edge detector SHALL be sub-module i2c_sync_edge, instantiated once each for scl and sda.

Verification
REQ-031 Master write addr 7'h50, data 8'hA5, rx_ready=1 → address ACK, rx_data=8'hA5, one rx_valid pulse, data ACK, busy low after STOP.
REQ-032 Master read addr 7'h50, tx_data 8'h3C then 8'hC3, master ACK then NACK → bus bytes 3C, C3; two tx_req pulses; IDLE afterwards.
REQ-033 Address 7'h51 → SDA never driven low, busy stays 0, no rx_valid or tx_req.
REQ-034 Write with rx_ready=0 on the 2nd byte → 1st byte ACKed, 2nd NACKed, both pulse rx_valid, state IDLE.
REQ-035 Repeated START mid-write (write 8'h01, Sr, read) → read phase ACKed and returns tx_data.
REQ-036 rst asserted during RD_DATA with SDA low → SDA released next clk, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C responder/initiator state type and bus constants
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_t;

  localparam logic       ACK     = 1'b0;
  localparam logic       NACK    = 1'b1;
  localparam logic [3:0] BIT_MSB = 4'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - two-flop synchronizer with rise/fall event flags
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s_meta;
  logic s_sync;
  logic s_hist;

  // Synchronize the bus line and keep one cycle of history; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_hist <= 1'b1;
    end else begin
      s_meta <= din;
      s_sync <= s_meta;
      s_hist <= s_sync;
    end
  end

  assign level = s_sync;
  assign rise  = s_sync & ~s_hist;
  assign fall  = ~s_sync & s_hist;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C responder with byte receive and transmit handshakes
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [6:0] shift, shift_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [7:0] rx_data_n;
  logic       rw, rw_n;
  logic       ack_bit, ack_bit_n;
  logic       ack_slot, ack_slot_n;
  logic       sda_oe, sda_oe_n;
  logic       rx_valid_n, tx_req_n, busy_n;

  i2c_sync_edge u_scl (.clk(clk), .rst(rst), .din(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst(rst), .din(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  // Open-drain: only ever pull low, and let go as soon as reset is asserted
  assign sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= BIT_MSB;
      shift    <= 7'h00;
      tx_shift <= 8'h00;
      rw       <= 1'b0;
      ack_bit  <= NACK;
      ack_slot <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx_shift <= tx_shift_n;
      rw       <= rw_n;
      ack_bit  <= ack_bit_n;
      ack_slot <= ack_slot_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
    end
  end

  // Bus protocol: sample on SCL rise, change SDA drive on SCL fall;
  // ack_slot marks that the ACK bit (or the last data bit) is in progress
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_shift_n = tx_shift;
    rw_n       = rw;
    ack_bit_n  = ack_bit;
    ack_slot_n = ack_slot;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;

    if (stop) begin
      state_n    = IDLE;
      sda_oe_n   = 1'b0;
      ack_slot_n = 1'b0;
      busy_n     = 1'b0;
    end else if (start) begin
      state_n    = ADDR;
      bit_cnt_n  = BIT_MSB;
      sda_oe_n   = 1'b0;
      ack_slot_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shift_n = {shift[5:0], sda_lvl};
          if (bit_cnt == 4'd0) begin
            if (shift == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              rw_n    = sda_lvl;
              busy_n  = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            bit_cnt_n = bit_cnt - 4'd1;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_slot) begin
            sda_oe_n   = 1'b1;
            ack_slot_n = 1'b1;
          end else begin
            ack_slot_n = 1'b0;
            bit_cnt_n  = BIT_MSB;
            if (rw) begin
              state_n    = RD_DATA;
              tx_shift_n = tx_data;
              tx_req_n   = 1'b1;
              sda_oe_n   = ~tx_data[7];
            end else begin
              state_n  = WR_DATA;
              sda_oe_n = 1'b0;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_n = {shift[5:0], sda_lvl};
          if (bit_cnt == 4'd0) begin
            rx_data_n  = {shift, sda_lvl};
            rx_valid_n = 1'b1;
            ack_bit_n  = rx_ready ? ACK : NACK;
            ack_slot_n = 1'b0;
            state_n    = WR_ACK;
          end else begin
            bit_cnt_n = bit_cnt - 4'd1;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_slot) begin
            sda_oe_n   = (ack_bit == ACK);
            ack_slot_n = 1'b1;
          end else begin
            sda_oe_n   = 1'b0;
            ack_slot_n = 1'b0;
            if (ack_bit == ACK) begin
              state_n   = WR_DATA;
              bit_cnt_n = BIT_MSB;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            if (bit_cnt == 4'd0) ack_slot_n = 1'b1;
            else                 bit_cnt_n  = bit_cnt - 4'd1;
          end else if (scl_fall) begin
            if (ack_slot) begin
              sda_oe_n   = 1'b0;
              ack_slot_n = 1'b0;
              state_n    = RD_ACK;
            end else begin
              sda_oe_n = ~tx_shift[bit_cnt[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == ACK) begin
              ack_slot_n = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && ack_slot) begin
            ack_slot_n = 1'b0;
            bit_cnt_n  = BIT_MSB;
            tx_shift_n = tx_data;
            tx_req_n   = 1'b1;
            sda_oe_n   = ~tx_data[7];
            state_n    = RD_DATA;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - scoreboard bench for i2c_slave driven by a bit-banged master
module tb_i2c_slave;

  localparam int Q = 6;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  wire        scl;
  wire        sda;

  assign scl = m_scl;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rx_pulses = 0;
  int         tx_pulses = 0;
  bit         slave_low_seen = 0;
  bit         busy_seen = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] tx_src[$];

  // Advance n clocks, sampling 1 time unit after each edge; pops the receive scoreboard
  task automatic tick(input int n);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
        rx_pulses++;
        checks++;
        if (rx_exp.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data);
        end else begin
          exp = rx_exp.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_data: got %h, required %h", rx_data, exp);
          end
        end
      end
      if (tx_req) begin
        tx_pulses++;
        if (tx_src.size() > 0) tx_data = tx_src.pop_front();
      end
      if (rx_valid || tx_req) begin
        checks++;
        if (rx_valid && tx_req) begin
          errors++;
          $display("FAIL pulse_overlap: rx_valid=%b tx_req=%b, required not both", rx_valid, tx_req);
        end
      end
      if (sda === 1'b0 && m_sda) slave_low_seen = 1;
      if (busy) busy_seen = 1;
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(H);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(H / 2);
    b = sda;      tick(H / 2);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = (b === 1'b0);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack ? 1'b0 : 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL reset_sda: got %b, required 1", sda); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    checks++; if (tx_req !== 1'b0)   begin errors++; $display("FAIL reset_tx_req: got %b, required 0", tx_req); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_write();
    logic ack;
    int   rx0 = rx_pulses;
    rx_ready = 1'b1;
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1)  begin errors++; $display("FAIL wr_addr_ack: got %b, required 1", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, required 1", busy); end
    rx_exp.push_back(8'hA5);
    write_byte(8'hA5, ack);
    checks++; if (ack !== 1'b1)  begin errors++; $display("FAIL wr_data_ack: got %b, required 1", ack); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b, required 0", busy); end
    checks++; if (rx_pulses - rx0 != 1) begin errors++; $display("FAIL wr_rx_pulses: got %0d, required 1", rx_pulses - rx0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr_rx_hold: got %h, required a5", rx_data); end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] got, exp;
    int         tx0 = tx_pulses;
    tx_data = 8'h3C;
    tx_src.push_back(8'hC3);
    rd_exp.push_back(8'h3C);
    rd_exp.push_back(8'hC3);
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b, required 1", ack); end
    read_byte(1'b1, got);
    exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rd_byte0: got %h, required %h", got, exp); end
    read_byte(1'b0, got);
    exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rd_byte1: got %h, required %h", got, exp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_after_nack: busy=%b, required 0", busy); end
    bus_stop();
    checks++; if (tx_pulses - tx0 != 2) begin errors++; $display("FAIL rd_tx_pulses: got %0d, required 2", tx_pulses - tx0); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int   rx0 = rx_pulses;
    int   tx0 = tx_pulses;
    slave_low_seen = 0;
    busy_seen = 0;
    bus_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wa_addr_nack: acked=%b, required 0", ack); end
    write_byte(8'h55, ack);
    bus_stop();
    checks++; if (slave_low_seen) begin errors++; $display("FAIL wa_sda_driven: got 1, required 0"); end
    checks++; if (busy_seen) begin errors++; $display("FAIL wa_busy: got 1, required 0"); end
    checks++; if (rx_pulses != rx0 || tx_pulses != tx0) begin
      errors++; $display("FAIL wa_pulses: rx %0d tx %0d, required 0 0", rx_pulses - rx0, tx_pulses - tx0);
    end
  endtask

  task automatic test_back_to_back_nack();
    logic ack;
    int   rx0 = rx_pulses;
    rx_ready = 1'b1;
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nk_addr_ack: got %b, required 1", ack); end
    rx_exp.push_back(8'h11);
    write_byte(8'h11, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nk_byte0_ack: got %b, required 1", ack); end
    rx_ready = 1'b0;
    rx_exp.push_back(8'h22);
    write_byte(8'h22, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nk_byte1_nack: acked=%b, required 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nk_idle: busy=%b, required 0", busy); end
    bus_stop();
    rx_ready = 1'b1;
    checks++; if (rx_pulses - rx0 != 2) begin errors++; $display("FAIL nk_rx_pulses: got %0d, required 2", rx_pulses - rx0); end
  endtask

  task automatic test_repeated_start();
    logic       ack;
    logic [7:0] got, exp;
    rx_ready = 1'b1;
    bus_start();
    write_byte(8'hA0, ack);
    rx_exp.push_back(8'h01);
    write_byte(8'h01, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rs_wr_ack: got %b, required 1", ack); end
    tx_data = 8'h5A;
    rd_exp.push_back(8'h5A);
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rs_rd_addr_ack: got %b, required 1", ack); end
    read_byte(1'b0, got);
    exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rs_rd_byte: got %h, required %h", got, exp); end
    bus_stop();
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL mr_driving: sda=%b, required 0", sda); end
    rst = 1'b1;
    tick(1);
    checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL mr_sda_release: got %b, required 1", sda); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mr_rx_data: got %h, required 00", rx_data); end
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || tx_req !== 1'b0) begin
      errors++; $display("FAIL mr_outputs: busy=%b rx_valid=%b tx_req=%b, required 0 0 0", busy, rx_valid, tx_req);
    end
    rst = 1'b0;
    tick(4);
    bus_stop();
    rx_exp.push_back(8'h7E);
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mr_recover_ack: got %b, required 1", ack); end
    write_byte(8'h7E, ack);
    bus_stop();
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL mr_recover_data: got %h, required 7e", rx_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_back_to_back_nack();
    test_repeated_start();
    test_reset_mid_read();
    tick(10);
    checks++; if (rx_exp.size() != 0) begin errors++; $display("FAIL rx_outstanding: got %0d, required 0", rx_exp.size()); end
    checks++; if (rd_exp.size() != 0) begin errors++; $display("FAIL rd_outstanding: got %0d, required 0", rd_exp.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
